// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester arbiter for one shared ALU, with a one-entry registered
// response buffer, the CPSR flag register and saturating per-requester grant counters.
module alu_share_arbiter #(
  parameter bit PRIO_FIXED = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [31:0]      req0_op1,
  input  logic [31:0]      req0_op2,
  input  logic [31:0]      req1_op1,
  input  logic [31:0]      req1_op2,
  input  logic [3:0]       req0_opcode,
  input  logic [3:0]       req1_opcode,
  input  logic             req0_set_cond,
  input  logic             req1_set_cond,
  output logic [31:0]      alu_op1,
  output logic [31:0]      alu_op2,
  output logic [3:0]       alu_opcode,
  output logic             alu_set_cond,
  input  logic [31:0]      alu_result,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_nzcv,
  output logic [3:0]       cpsr_nzcv,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1,
  output logic             busy
);
  typedef enum logic {EMPTY, FULL} rsp_state_e;
  rsp_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_nzcv_q, rsp_nzcv_d;
  logic [3:0]       cpsr_q, cpsr_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             slot_free, win0, win1, grant, gid;
  logic [3:0]       flags;
  always_comb begin
    slot_free    = (state_q == EMPTY) | rsp_ready;
    // last_grant = 1 after reset hands the first contention to req0
    win0         = req0_valid & (!req1_valid | PRIO_FIXED | last_grant_q);
    win1         = req1_valid & !win0;
    req0_ready   = rst_n & slot_free & win0;
    req1_ready   = rst_n & slot_free & win1;
    grant        = req0_ready | req1_ready;
    gid          = req1_ready;
    alu_op1      = grant ? (gid ? req1_op1 : req0_op1) : 32'd0;
    alu_op2      = grant ? (gid ? req1_op2 : req0_op2) : 32'd0;
    alu_opcode   = grant ? (gid ? req1_opcode : req0_opcode) : 4'b1101;
    alu_set_cond = grant & (gid ? req1_set_cond : req0_set_cond);
    flags        = {alu_n, alu_z, alu_c, alu_v};
    state_d      = grant ? FULL : (rsp_ready ? EMPTY : state_q);
    last_grant_d = grant ? gid : last_grant_q;
    rsp_id_d     = grant ? gid : rsp_id_q;
    rsp_result_d = grant ? alu_result : rsp_result_q;
    rsp_nzcv_d   = grant ? flags : rsp_nzcv_q;
    cpsr_d       = alu_set_cond ? flags : cpsr_q;
    cnt0_d       = (req0_ready && cnt0_q != '1) ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d       = (req1_ready && cnt1_q != '1) ? cnt1_q + CNT_W'(1) : cnt1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_nzcv_q   <= '0;
      cpsr_q       <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_nzcv_q   <= rsp_nzcv_d;
      cpsr_q       <= cpsr_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end
  assign rsp_valid  = state_q == FULL;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_nzcv   = rsp_nzcv_q;
  assign cpsr_nzcv  = cpsr_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
  assign busy       = rsp_valid | req0_valid | req1_valid;
endmodule
